// File: rtl/stq_drain_if.sv
// Store-queue drain bus: RAM read port toward the store queue and write handshake toward the data cache.
// master = drain controller, slave = store-queue RAM plus cache side.
interface stq_drain_if #(
    parameter int INDEX = 4,
    parameter int WIDTH = 8
);
    logic [INDEX-1:0] rdAddr_o;
    logic [WIDTH-1:0] rdData_i;
    logic             dcWrValid_o;
    logic [WIDTH-1:0] dcWrData_o;
    logic             dcWrReady_i;
    logic             stqFree_o;

    modport master (
        output rdAddr_o,
        input  rdData_i,
        output dcWrValid_o,
        output dcWrData_o,
        input  dcWrReady_i,
        output stqFree_o
    );

    modport slave (
        input  rdAddr_o,
        output rdData_i,
        input  dcWrValid_o,
        input  dcWrData_o,
        output dcWrReady_i,
        input  stqFree_o
    );
endinterface

// File: rtl/stq_drain_ctrl.sv
// Store-queue drain controller: moves committed entries into a one-deep cache write slot.
// Define STQ_DRAIN_PERF_EN to add the stallCnt_o back-pressure cycle counter.
//
// state | meaning
// IDLE  | output slot empty, dcWrValid_o=0
// SEND  | output slot holds a write, dcWrValid_o=1
module stq_drain_ctrl #(
    parameter int DEPTH = 16,
    parameter int INDEX = 4,
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    stq_drain_if.master bus,
    input  logic [1:0]  commitCnt_i,
    input  logic        drainHalt_i,
    output logic        overflow_o
`ifdef STQ_DRAIN_PERF_EN
    ,
    output logic [31:0] stallCnt_o
`endif
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    localparam int CW = INDEX + 2;
    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

    state_t           state_q, state_d;
    logic [INDEX-1:0] head_q, head_d;
    logic [INDEX:0]   pend_q, pend_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;

    logic [1:0]    commit_eff;
    logic          load;
    logic [CW-1:0] sum;
    logic [CW-1:0] net;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            head_q  <= '0;
            pend_q  <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        data_d     = data_q;
        ovf_d      = ovf_q;
        commit_eff = (commitCnt_i == 2'd3) ? 2'd2 : commitCnt_i;
        load       = (pend_q != '0) && !drainHalt_i &&
                     (state_q == IDLE || bus.dcWrReady_i);
        sum        = CW'(pend_q) + CW'(commit_eff);
        net        = sum - CW'(load);

        // Overflow looks at the commit before the same-cycle load is subtracted.
        if (sum > DEPTH_W)
            ovf_d = 1'b1;
        if (net > DEPTH_W)
            pend_d = (INDEX+1)'(DEPTH);
        else
            pend_d = net[INDEX:0];

        if (load) begin
            data_d = bus.rdData_i;
            head_d = (head_q == INDEX'(DEPTH - 1)) ? '0 : head_q + 1'b1;
        end

        case (state_q)
            IDLE: if (load) state_d = SEND;
            SEND: if (!load && bus.dcWrReady_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.rdAddr_o    = head_q;
    assign bus.dcWrValid_o = (state_q == SEND);
    assign bus.dcWrData_o  = data_q;
    assign bus.stqFree_o   = (state_q == SEND) && bus.dcWrReady_i;
    assign overflow_o      = ovf_q;

`ifdef STQ_DRAIN_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_q <= '0;
        else
            stall_q <= stall_d;
    end

    always_comb begin
        stall_d = stall_q;
        if (state_q == SEND && !bus.dcWrReady_i && stall_q != '1)
            stall_d = stall_q + 32'd1;
    end

    assign stallCnt_o = stall_q;
`endif

endmodule
